// File: rtl/can_tx_serializer.sv
// CAN transmit serializer: shifts header and data MSB-first with on-the-fly CRC-15, then the CRC.
// Optional CAN_TX_BITPOS_EN adds a bitpos output giving the frame index of the bit on txbit.
module can_tx_serializer #(
    parameter logic [14:0] CRC_POLY  = 15'h4599,
    parameter int          MAX_BYTES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        abort,
    input  logic        bit_en,
    input  logic [38:0] message,
    input  logic        extended,
    input  logic [3:0]  tmlen,
    input  logic [63:0] data,
    output logic        txbit,
    output logic        busy,
    output logic        done,
    output logic [14:0] crc
`ifdef CAN_TX_BITPOS_EN
    ,
    output logic [6:0]  bitpos
`endif
);

    typedef enum logic [2:0] {IDLE, HEADER, DATA, CRCF, FIN} state_t;
    localparam logic [3:0] MAXB = 4'(MAX_BYTES);

    state_t      state_q, state_d;
    logic [38:0] msg_q, msg_d;
    logic        ext_q, ext_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  nbytes_q, nbytes_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        txbit_q, txbit_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [14:0] crc_q, crc_d;

    logic [5:0]  hidx, didx;
    logic        cur_bit;
    logic [14:0] crc_nx;
    logic        last_hdr, last_data;

`ifdef CAN_TX_BITPOS_EN
    logic [6:0]  gcnt_q, gcnt_d;
`endif

    always_comb begin
        // Basic frames send message[38] (SOF) followed by message[17:0]
        hidx      = ext_q ? 6'd38 - cnt_q[5:0]
                          : ((cnt_q == 7'd0) ? 6'd38 : 6'd18 - cnt_q[5:0]);
        didx      = 6'd63 - cnt_q[5:0];
        cur_bit   = (state_q == DATA) ? data_q[didx] : msg_q[hidx];
        crc_nx    = {crc_q[13:0], 1'b0} ^ ((cur_bit ^ crc_q[14]) ? CRC_POLY : 15'd0);
        last_hdr  = cnt_q == (ext_q ? 7'd38 : 7'd18);
        last_data = cnt_q == ({nbytes_q, 3'b000} - 7'd1);

        state_d  = state_q;
        msg_d    = msg_q;
        ext_d    = ext_q;
        data_d   = data_q;
        nbytes_d = nbytes_q;
        cnt_d    = cnt_q;
        txbit_d  = txbit_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        crc_d    = crc_q;
`ifdef CAN_TX_BITPOS_EN
        gcnt_d   = gcnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (load) begin
                    msg_d    = message;
                    ext_d    = extended;
                    data_d   = data;
                    nbytes_d = (tmlen > MAXB) ? MAXB : tmlen;
                    crc_d    = 15'd0;
                    cnt_d    = 7'd0;
                    busy_d   = 1'b1;
                    state_d  = HEADER;
`ifdef CAN_TX_BITPOS_EN
                    gcnt_d   = 7'd0;
`endif
                end
            end
            HEADER, DATA: begin
                if (bit_en) begin
                    txbit_d = cur_bit;
                    crc_d   = crc_nx;
                    cnt_d   = cnt_q + 7'd1;
                    if (state_q == HEADER && last_hdr) begin
                        cnt_d   = 7'd0;
                        state_d = (nbytes_q != 4'd0) ? DATA : CRCF;
                    end else if (state_q == DATA && last_data) begin
                        cnt_d   = 7'd0;
                        state_d = CRCF;
                    end
`ifdef CAN_TX_BITPOS_EN
                    gcnt_d  = gcnt_q + 7'd1;
`endif
                end
            end
            CRCF: begin
                // crc_q is frozen here and acts as the snapshot being shifted out
                if (bit_en) begin
                    txbit_d = crc_q[4'd14 - cnt_q[3:0]];
                    cnt_d   = cnt_q + 7'd1;
                    if (cnt_q == 7'd14) begin
                        cnt_d   = 7'd0;
                        state_d = FIN;
                    end
`ifdef CAN_TX_BITPOS_EN
                    gcnt_d  = gcnt_q + 7'd1;
`endif
                end
            end
            FIN: begin
                if (bit_en) begin
                    txbit_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef CAN_TX_BITPOS_EN
                    gcnt_d  = 7'd0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            txbit_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = 7'd0;
            crc_d   = crc_q;
`ifdef CAN_TX_BITPOS_EN
            gcnt_d  = 7'd0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            ext_q    <= 1'b0;
            data_q   <= '0;
            nbytes_q <= '0;
            cnt_q    <= '0;
            txbit_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            crc_q    <= '0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            ext_q    <= ext_d;
            data_q   <= data_d;
            nbytes_q <= nbytes_d;
            cnt_q    <= cnt_d;
            txbit_q  <= txbit_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            crc_q    <= crc_d;
        end
    end

`ifdef CAN_TX_BITPOS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) gcnt_q <= '0;
        else       gcnt_q <= gcnt_d;
    end
    assign bitpos = (gcnt_q == 7'd0) ? 7'd0 : gcnt_q - 7'd1;
`endif

    assign txbit = txbit_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign crc   = crc_q;

endmodule

// File: doc/can_tx_serializer.md
Name: can_tx_serializer

Overview:
- Transmit-side stage directly downstream of the frame encapsulation unit.
- Captures the assembled 39-bit header (SOF/ID/RTR/IDE/r0/r1/DLC), the real data length and up to 8 data bytes.
- Serialises SOF through the data field MSB-first, one bit per bit-timing strobe, computing CRC-15 on the fly, then appends the 15 CRC bits.
- Output feeds the bit-stuffing/transmit logic; stuffing, delimiters, ACK and EOF are out of scope.

Parameters:
- CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial without the x^15 term.
- MAX_BYTES, 8, data-byte clip limit.

Ports:
- clock  input  1  main clock
- reset  input  1  asynchronous reset, active-high
- load  input  1  one-cycle start request; honoured only in IDLE
- abort  input  1  abandon frame (arbitration loss/error), any state
- bit_en  input  1  one-cycle strobe per nominal bit from bit timing
- message  input  39  header from encapsulation; [38]=SOF, layout per extended
- extended  input  1  1: header is message[38:0] (39 bits); 0: message[38] then message[17:0] (19 bits)
- tmlen  input  4  real data length in bytes (0 for RTR)
- data  input  64  payload; byte0=[63:56], MSB of each byte sent first
- txbit  output  1  serial bit, 1 = recessive
- busy  output  1  high from accepted load until return to IDLE
- done  output  1  one-cycle pulse at normal frame completion
- crc  output  15  running CRC register

Behaviour:
- Reset (async, immediate): state=IDLE, txbit=1, busy=0, done=0, crc=0, all counters 0.
- States: IDLE, HEADER, DATA, CRCF, FIN.
- IDLE:
  - load=1 latches message, extended, data and nbytes=min(tmlen,8).
  - crc<=0, bit counter<=0, busy<=1, state<=HEADER.
  - txbit stays 1 until the first bit_en.
- Bit rule (HEADER, DATA), on each bit_en:
  - txbit<=current bit.
  - crc<=(crc<<1)^(CRC_POLY if (bit^crc[14]) else 0), truncated to 15 bits.
  - counter increments.
- HEADER:
  - 19 bits (basic) or 39 bits (extended).
  - After the last header bit: DATA if nbytes>0, else CRCF.
- DATA: nbytes*8 bits from data[63] downward; after the last bit go to CRCF.
- CRCF:
  - Snapshot crc at entry; on each bit_en shift out the snapshot MSB-first, 15 bits.
  - crc output holds the snapshot; no further updates.
  - After the 15th bit go to FIN.
- FIN: on next bit_en, txbit<=1, done<=1 for one cycle, busy<=0, state<=IDLE.
- Bit totals (strobes from load to done): basic 19+8n+15+1, extended 39+8n+15+1.
- No output changes on cycles without bit_en, except done deassertion and the load capture.
- tmlen 9..15 is treated as 8.
- abort=1 in any non-IDLE state: next edge gives state=IDLE, txbit=1, busy=0, done=0; crc holds its value.
- abort has priority over bit_en in the same cycle; abort in IDLE is ignored.
- load while busy is ignored; inputs may change after the load cycle without effect.
- load and bit_en in the same IDLE cycle: load is accepted, the bit_en is not consumed, and the first bit goes out on the next bit_en.

Optional Feature:
- Macro: CAN_TX_BITPOS_EN.
- When defined:
  - Extra output bitpos[6:0] = index of the bit currently on txbit, counted from SOF=0 through the last CRC bit.
  - bitpos holds 0 in IDLE and in reset.
  - Supports error-frame placement and bench checks.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Basic zero frame: message=0, extended=0, tmlen=0 → 19 zeros, CRC bits 000000000000000, txbit=1 plus done on the 35th bit_en.
- Single-one CRC check: message=0, extended=0, tmlen=1, data[63:56]=8'h01 → 19+8 bits with only the 27th bit =1, then CRC 100010110011001 (15'h4599).
- Extended full frame: extended=1, tmlen=8, arbitrary data → exactly 39+64+15 serial bits, busy high throughout, done on the 119th bit_en, bits matching the reference model.
- DLC clip: tmlen=4'hF, basic → same bit count (19+64+15) as tmlen=8.
- Abort mid-DATA: abort after the 25th bit_en → txbit=1 and busy=0 next cycle, no done; a subsequent load starts cleanly with crc=0.
- Reset and load edge cases: reset asserted mid-CRCF → outputs return to reset values immediately; load while busy is ignored; load and bit_en together in IDLE → the SOF appears on the following bit_en.
